uart_tx_param: RTL

Parametrised UART transmitter. Serialises one word per valid/ready handshake into an asynchronous serial frame: start bit, DATA_BITS data bits LSB first, optional parity bit, 1 or 2 stop bits.
Generalises the fixed 8N1 transmitter with configurable width, parity and stop bits, a proper handshake, a frame-done pulse and an optional input FIFO.
Sits between the character source logic and a PMOD/pin output.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 56 +++++
 rtl/uart_tx_param.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity encodings,
// FSM state type and the clocks-per-bit rounding helper.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned div_round(input int unsigned clk_freq,
                                            input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering words ahead of the UART transmitter FSM.
// Depth must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: Depth must be a power of two and at least 2");
  end

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS data LSB first, optional parity, 1-2 stops.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO in front of the FSM.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 12000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned DIV       = div_round(CLK_FREQ, BAUD);
  localparam int unsigned CntW      = $clog2(DIV);
  localparam int unsigned BitW      = 4;
  localparam bit          HasParity = (PARITY != PAR_NONE);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_param: clocks per bit must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  tx_state_e            state_q, state_d;
  logic [CntW-1:0]      baud_q, baud_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 done_q, done_d;

  logic                 word_avail;
  logic [DATA_BITS-1:0] word;
  logic                 take;
  logic                 bit_end;

  assign take = (state_q == StIdle) & word_avail;

`ifdef UART_TX_FIFO_EN
  logic fifo_full, fifo_empty;

  uart_tx_fifo #(
    .Width(DATA_BITS),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (tx_valid),
    .wdata(tx_data),
    .pop  (take),
    .rdata(word),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign tx_ready   = ~fifo_full;
  assign word_avail = ~fifo_empty;
  assign tx_busy    = (state_q != StIdle) | ~fifo_empty;
`else
  // Depth is meaningful only with the FIFO compiled in.
  if (FIFO_DEPTH == 0) begin : g_no_fifo
  end

  assign tx_ready   = (state_q == StIdle);
  assign word_avail = tx_valid;
  assign word       = tx_data;
  assign tx_busy    = (state_q != StIdle);
`endif

  assign bit_end = (baud_q == CntW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    // Wrapping at the bit boundary also clears the counter on every state entry.
    if (state_q != StIdle) begin
      baud_d = bit_end ? '0 : baud_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (take) begin
          shift_d = word;
          par_d   = (PARITY == PAR_ODD) ? ~^word : ^word;
          bit_d   = '0;
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == BitW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = HasParity ? StParity : StStop;
          end else begin
            bit_d   = bit_q + BitW'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          if (bit_q == BitW'(STOP_BITS - 1)) begin
            bit_d   = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // txd is registered from the next state so the line moves on the same edge as the FSM.
    unique case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_d[0];
      StParity: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  assign txd     = txd_q;
  assign tx_done = done_q;

endmodule
